pipelined_barrel_shifter: RTL
=============================

PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 Parameter XLEN, default 32, SHALL set data width; legal values 32 and 64.
REQ-002 Parameter STAGES, default 2, SHALL set the number of register stages; legal range 1..log2(XLEN).
REQ-003 Port clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  SHALL be the synchronous active-high reset.
REQ-005 Port in_valid  input  1  SHALL mark the input operation as valid.
REQ-006 Port in_ready  output  1  SHALL indicate the block accepts an operation this cycle.
REQ-007 Port in_data  input  XLEN  SHALL carry the operand.
REQ-008 Port shamt  input  log2(XLEN)  SHALL carry the shift amount.
REQ-009 Port left_or_right_shift  input  1  SHALL select the direction: 1 = left, 0 = right.
REQ-010 Port arithmetic_right_shift  input  1  SHALL select sign fill on right shifts; it is ignored on left shifts and rotates.
REQ-011 Port rotate  input  1  SHALL select rotate instead of shift.
REQ-012 Port word_op  input  1  SHALL select a 32-bit word operation; it is ignored when XLEN=32.
REQ-013 Port out_valid  output  1  SHALL mark out_data as valid.
REQ-014 Port out_ready  input  1  SHALL indicate the consumer accepts out_data.
REQ-015 Port out_data  output  XLEN  SHALL carry the registered result.

Function
REQ-016 A transfer SHALL occur on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
REQ-017 in_ready SHALL equal !out_valid || out_ready, so the whole pipeline stalls while the output is held.
REQ-018 While stalled, every stage register, including out_data and out_valid, SHALL hold its value.
REQ-019 Latency SHALL be exactly STAGES cycles from input transfer to out_valid=1 with no stall; throughput SHALL be 1 operation per cycle.
REQ-020 Each stage SHALL carry a valid bit; bubbles SHALL propagate as valid=0 and SHALL never raise out_valid.
REQ-021 The log2(XLEN) mux levels SHALL be distributed over STAGES with ceil(levels/STAGES) levels per stage; the last stage drives the output register.
REQ-022 Left shift SHALL compute in_data << shamt with zero fill.
REQ-023 Logical right shift SHALL compute in_data >> shamt with zero fill.
REQ-024 Arithmetic right shift SHALL fill the vacated positions with in_data[XLEN-1].
REQ-025 Rotate SHALL compute a circular shift in the selected direction; arithmetic_right_shift has no effect on it.
REQ-026 word_op=1 with XLEN=64 SHALL operate on in_data[31:0] with shamt[4:0] and sign-extend result bit 31 into out_data[63:32]; shamt[5] is ignored.
REQ-027 For word_op arithmetic right shifts, the fill bit SHALL be in_data[31].
REQ-028 shamt=0 SHALL return in_data unchanged (sign-extended when word_op=1 and XLEN=64).
REQ-029 Control bits SHALL be captured with the operand and travel alongside the data, so mixed operations in flight SHALL not interfere.
REQ-030 out_data SHALL remain stable from the cycle out_valid rises until its output transfer.

Reset
REQ-031 With reset=1 at a clock edge, all stage valid bits and out_valid SHALL become 0 and out_data SHALL become 0.
REQ-032 Reset mid-operation SHALL discard every in-flight operation; no result issued before reset SHALL appear afterwards.
REQ-033 During reset, in_ready SHALL be 1 (as out_valid=0), but no input transfer SHALL be recorded in the reset cycle.
REQ-034 The first input transfer after reset deasserts SHALL yield out_valid exactly STAGES cycles later.

Verification
REQ-035 XLEN=32, STAGES=2: in_data=0x80000001, shamt=4, left, out_ready=1 -> out_data=0x00000010 with out_valid 2 cycles later.
REQ-036 XLEN=32: in_data=0x80000000, shamt=31, right, arithmetic=1 -> 0xFFFFFFFF; the same with arithmetic=0 -> 0x00000001.
REQ-037 XLEN=32: rotate right, in_data=0x00000001, shamt=1 -> 0x80000000; rotate left, in_data=0x80000000, shamt=1 -> 0x00000001.
REQ-038 XLEN=64, word_op=1: in_data=0xFFFFFFFF_40000000, shamt=33, left -> 0xFFFFFFFF_80000000; shamt[5] ignored, upper bits taken from result bit 31.
REQ-039 Back-to-back issue of 8 operations with out_ready held 0 for 3 cycles mid-stream -> all 8 results appear in order, none lost or duplicated, and out_data is stable while stalled.
REQ-040 Assert reset with 2 operations in flight -> out_valid=0 and out_data=0 next cycle, and neither flushed result ever appears.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: shift/rotate left or right, optional sign fill, optional 32-bit word op.
// Latency STAGES cycles, one operation per cycle; log2(XLEN) mux levels spread over the stages.
// Backpressure: in_ready = !out_valid || out_ready; the whole pipeline freezes while the output is held.
// Ports: clock/reset (sync, active-high); in_valid/in_ready/in_data/shamt plus control bits
//        (left_or_right_shift, arithmetic_right_shift, rotate, word_op); out_valid/out_ready/out_data.
module pipelined_barrel_shifter #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_data,
  input  logic [$clog2(XLEN)-1:0] shamt,
  input  logic                    left_or_right_shift,
  input  logic                    arithmetic_right_shift,
  input  logic                    rotate,
  input  logic                    word_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_data
);

  localparam int LEVELS = $clog2(XLEN);
  localparam int LPS    = (LEVELS + STAGES - 1) / STAGES;

  // Control travelling with each operand.
  typedef struct packed {
    logic              left;
    logic              rot;
    logic              fill;
    logic              word;
    logic [LEVELS-1:0] amt;
  } ctl_t;

  logic [XLEN-1:0] dat_q   [STAGES];
  logic [XLEN-1:0] dat_d   [STAGES];
  logic [XLEN-1:0] src_dat [STAGES];
  ctl_t            ctl_q   [STAGES];
  ctl_t            src_ctl [STAGES];
  logic [STAGES-1:0] vld_q;

  logic [XLEN-1:0] pre_dat;
  ctl_t            pre_ctl;
  logic            word_en;
  logic            advance;

  assign word_en   = (XLEN == 64) && word_op;
  assign out_valid = vld_q[STAGES-1];
  assign out_data  = dat_q[STAGES-1];
  assign in_ready  = !out_valid || out_ready;
  assign advance   = in_ready;

  // One mux level: shift/rotate by a fixed power of two.
  function automatic logic [XLEN-1:0] shift_lvl(input logic [XLEN-1:0] x, input int sh,
                                                input logic left, input logic rot,
                                                input logic fill);
    logic [XLEN-1:0] mask;
    mask = ~({XLEN{1'b1}} >> sh);
    if (left) begin
      shift_lvl = rot ? ((x << sh) | (x >> (XLEN - sh))) : (x << sh);
    end else if (rot) begin
      shift_lvl = (x >> sh) | (x << (XLEN - sh));
    end else begin
      shift_lvl = (x >> sh) | (fill ? mask : '0);
    end
  endfunction

  // Word ops reuse the full-width datapath: the upper half is preloaded so that
  // the low 32 bits come out right (copy of the word for rotates, sign bit for
  // arithmetic right shifts, zero otherwise), and shamt[5] is dropped.
  always_comb begin
    pre_dat      = in_data;
    pre_ctl.left = left_or_right_shift;
    pre_ctl.rot  = rotate;
    pre_ctl.word = word_en;
    pre_ctl.amt  = shamt;
    if (word_en) begin
      for (int i = 32; i < XLEN; i++) begin
        pre_dat[i] = rotate ? in_data[i-32]
                            : (!left_or_right_shift && arithmetic_right_shift && in_data[31]);
      end
      for (int i = 5; i < LEVELS; i++) begin
        pre_ctl.amt[i] = 1'b0;
      end
    end
    pre_ctl.fill = !left_or_right_shift && !rotate && arithmetic_right_shift
                   && pre_dat[XLEN-1];
  end

  // Stage s applies mux levels [s*LPS, (s+1)*LPS); the last stage also
  // sign-extends word results from bit 31.
  always_comb begin
    src_dat[0] = pre_dat;
    src_ctl[0] = pre_ctl;
    for (int s = 1; s < STAGES; s++) begin
      src_dat[s] = dat_q[s-1];
      src_ctl[s] = ctl_q[s-1];
    end
    for (int s = 0; s < STAGES; s++) begin
      dat_d[s] = src_dat[s];
      for (int l = 0; l < LEVELS; l++) begin
        if (((l / LPS) == s) && src_ctl[s].amt[l]) begin
          dat_d[s] = shift_lvl(dat_d[s], 1 << l, src_ctl[s].left, src_ctl[s].rot,
                               src_ctl[s].fill);
        end
      end
      if ((s == STAGES - 1) && src_ctl[s].word) begin
        for (int i = 32; i < XLEN; i++) begin
          dat_d[s][i] = dat_d[s][31];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        dat_q[s] <= '0;
        ctl_q[s] <= '0;
      end
    end else if (advance) begin
      vld_q[0] <= in_valid;
      for (int s = 1; s < STAGES; s++) begin
        vld_q[s] <= vld_q[s-1];
      end
      for (int s = 0; s < STAGES; s++) begin
        dat_q[s] <= dat_d[s];
        ctl_q[s] <= src_ctl[s];
      end
    end
  end

endmodule
